// File: rtl/avs_frame_source_pkg.sv
// Shared types and constants for the synthetic Avalon-ST frame source.
package avs_frame_source_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SOF,
        ST_HBLANK,
        ST_TEMP,
        ST_LINE,
        ST_EOF,
        ST_VBLANK
    } state_t;

    typedef enum logic [1:0] {
        PAT_HRAMP = 2'd0,
        PAT_VRAMP = 2'd1,
        PAT_CONST = 2'd2,
        PAT_LFSR  = 2'd3
    } pattern_t;

    localparam logic [3:0] ADDR_CTRL      = 4'd0;
    localparam logic [3:0] ADDR_CONST     = 4'd1;
    localparam logic [3:0] ADDR_TEMP      = 4'd2;
    localparam logic [3:0] ADDR_HBLANK    = 4'd3;
    localparam logic [3:0] ADDR_VBLANK    = 4'd4;
    localparam logic [3:0] ADDR_FRAME_CNT = 4'd5;
    localparam logic [3:0] ADDR_STATUS    = 4'd6;

    typedef logic [15:0] lfsr_t;

    // Taps for x^16 + x^14 + x^13 + x^11 + 1, shifting towards the MSB.
    localparam lfsr_t LFSR_TAPS = 16'hB400;

    function automatic lfsr_t lfsr_next(input lfsr_t s);
        return {s[14:0], ^(s & LFSR_TAPS)};
    endfunction

endpackage

// File: rtl/frame_lfsr16.sv
// 16-bit Fibonacci LFSR used as the noise pixel pattern; load has priority over step.
module frame_lfsr16
    import avs_frame_source_pkg::*;
#(
    parameter lfsr_t SEED = 16'hACE1
) (
    input  logic  clk,
    input  logic  srst,
    input  logic  i_load,
    input  logic  i_step,
    output lfsr_t o_state
);

    lfsr_t r_state;

    always_ff @(posedge clk) begin
        if (srst) begin
            r_state <= SEED;
        end else if (i_load) begin
            r_state <= SEED;
        end else if (i_step) begin
            r_state <= lfsr_next(r_state);
        end
    end

    assign o_state = r_state;

endmodule

// File: rtl/avs_frame_source.sv
// Synthetic 14-bit video frame generator with per-line temperature header and
// an Avalon-MM control slave; register values are shadowed at each SOF.
module avs_frame_source
    import avs_frame_source_pkg::*;
#(
    parameter int          video_width    = 640,
    parameter int          video_height   = 512,
    parameter int          hblank_default = 16,
    parameter int          vblank_default = 64,
    parameter logic [15:0] lfsr_seed      = 16'hACE1
) (
    input  logic        avs_clk,
    input  logic        avs_reset,
    output logic        avs_source_sof,
    output logic        avs_source_valid,
    output logic [15:0] avs_source_data,
    output logic        avs_source_eof,
    input  logic        avmm_slv_wr,
    input  logic        avmm_slv_rd,
    input  logic [3:0]  avmm_slv_address,
    input  logic [31:0] avmm_slv_wrdata,
    output logic [31:0] avmm_slv_rddata
);

    localparam logic [15:0] W_LAST = 16'(video_width - 1);
    localparam logic [15:0] H_LAST = 16'(video_height - 1);

    logic        r_enable;
    pattern_t    r_pattern;
    logic [13:0] r_const;
    logic [15:0] r_temp, r_hblank, r_vblank;
    logic [31:0] r_frame_cnt, r_rddata;

    pattern_t    r_sh_pattern;
    logic [13:0] r_sh_const;
    logic [15:0] r_sh_temp, r_sh_hblank, r_sh_vblank;

    state_t      r_state, w_state_next;
    logic [15:0] r_cnt, w_cnt_next, r_line, w_line_next;
    logic        r_sof, r_valid, r_eof;
    logic [15:0] r_data, w_data_next;
    logic        w_latch, w_lfsr_load, w_lfsr_step, w_frame_done;
    logic [13:0] w_pixel;
    logic [31:0] w_rd_mux;
    lfsr_t       w_lfsr;

    frame_lfsr16 #(.SEED(lfsr_seed)) u_lfsr (
        .clk     (avs_clk),
        .srst    (avs_reset),
        .i_load  (w_lfsr_load),
        .i_step  (w_lfsr_step),
        .o_state (w_lfsr)
    );

    always_comb begin
        w_state_next = r_state;
        w_cnt_next   = r_cnt;
        w_line_next  = r_line;
        w_latch      = 1'b0;
        w_lfsr_load  = 1'b0;
        w_frame_done = 1'b0;
        case (r_state)
            ST_IDLE: if (r_enable) begin
                w_state_next = ST_SOF;
                w_latch      = 1'b1;
                w_lfsr_load  = 1'b1;
                w_cnt_next   = '0;
                w_line_next  = '0;
            end
            ST_SOF: begin
                w_state_next = ST_HBLANK;
                w_cnt_next   = '0;
            end
            ST_HBLANK: if (r_cnt == r_sh_hblank - 16'd1) begin
                w_state_next = ST_TEMP;
                w_cnt_next   = '0;
            end else begin
                w_cnt_next   = r_cnt + 16'd1;
            end
            ST_TEMP: begin
                w_state_next = ST_LINE;
                w_cnt_next   = '0;
            end
            ST_LINE: if (r_cnt == W_LAST) begin
                w_cnt_next = '0;
                if (r_line == H_LAST) begin
                    w_state_next = ST_EOF;
                end else begin
                    w_state_next = ST_HBLANK;
                    w_line_next  = r_line + 16'd1;
                end
            end else begin
                w_cnt_next = r_cnt + 16'd1;
            end
            ST_EOF: begin
                w_frame_done = 1'b1;
                w_cnt_next   = '0;
                w_state_next = (r_sh_vblank == 16'd0) ? ST_IDLE : ST_VBLANK;
            end
            ST_VBLANK: if (r_cnt == r_sh_vblank - 16'd1) begin
                w_state_next = ST_IDLE;
            end else begin
                w_cnt_next   = r_cnt + 16'd1;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Pixel for the cycle being entered; the LFSR advances as its value is emitted.
    always_comb begin
        case (r_sh_pattern)
            PAT_HRAMP: w_pixel = w_cnt_next[13:0];
            PAT_VRAMP: w_pixel = r_line[13:0];
            PAT_CONST: w_pixel = r_sh_const;
            default:   w_pixel = w_lfsr[13:0];
        endcase
        w_lfsr_step = (w_state_next == ST_LINE);
        case (w_state_next)
            ST_TEMP: w_data_next = r_sh_temp;
            ST_LINE: w_data_next = {2'b00, w_pixel};
            default: w_data_next = 16'h0000;
        endcase
    end

    always_ff @(posedge avs_clk) begin
        if (avs_reset) begin
            r_state      <= ST_IDLE;
            r_cnt        <= '0;
            r_line       <= '0;
            r_sof        <= 1'b0;
            r_valid      <= 1'b0;
            r_eof        <= 1'b0;
            r_data       <= '0;
            r_sh_pattern <= PAT_HRAMP;
            r_sh_const   <= '0;
            r_sh_temp    <= '0;
            r_sh_hblank  <= 16'd1;
            r_sh_vblank  <= '0;
        end else begin
            r_state <= w_state_next;
            r_cnt   <= w_cnt_next;
            r_line  <= w_line_next;
            r_sof   <= (w_state_next == ST_SOF);
            r_eof   <= (w_state_next == ST_EOF);
            r_valid <= (w_state_next == ST_SOF) || (w_state_next == ST_TEMP) ||
                       (w_state_next == ST_LINE) || (w_state_next == ST_EOF);
            r_data  <= w_data_next;
            if (w_latch) begin
                r_sh_pattern <= r_pattern;
                r_sh_const   <= r_const;
                r_sh_temp    <= r_temp;
                r_sh_hblank  <= (r_hblank == 16'd0) ? 16'd1 : r_hblank;
                r_sh_vblank  <= r_vblank;
            end
        end
    end

    always_comb begin
        case (avmm_slv_address)
            ADDR_CTRL:      w_rd_mux = {29'd0, r_pattern, r_enable};
            ADDR_CONST:     w_rd_mux = {18'd0, r_const};
            ADDR_TEMP:      w_rd_mux = {16'd0, r_temp};
            ADDR_HBLANK:    w_rd_mux = {16'd0, r_hblank};
            ADDR_VBLANK:    w_rd_mux = {16'd0, r_vblank};
            ADDR_FRAME_CNT: w_rd_mux = r_frame_cnt;
            ADDR_STATUS:    w_rd_mux = {31'd0, (r_state != ST_IDLE)};
            default:        w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge avs_clk) begin
        if (avs_reset) begin
            r_enable    <= 1'b0;
            r_pattern   <= PAT_HRAMP;
            r_const     <= '0;
            r_temp      <= '0;
            r_hblank    <= 16'(hblank_default);
            r_vblank    <= 16'(vblank_default);
            r_frame_cnt <= '0;
            r_rddata    <= '0;
        end else begin
            r_rddata <= avmm_slv_rd ? w_rd_mux : 32'd0;
            if (w_frame_done) begin
                r_frame_cnt <= r_frame_cnt + 32'd1;
            end
            if (avmm_slv_wr) begin
                case (avmm_slv_address)
                    ADDR_CTRL: begin
                        r_enable  <= avmm_slv_wrdata[0];
                        r_pattern <= pattern_t'(avmm_slv_wrdata[2:1]);
                    end
                    ADDR_CONST:  r_const  <= avmm_slv_wrdata[13:0];
                    ADDR_TEMP:   r_temp   <= avmm_slv_wrdata[15:0];
                    ADDR_HBLANK: r_hblank <= avmm_slv_wrdata[15:0];
                    ADDR_VBLANK: r_vblank <= avmm_slv_wrdata[15:0];
                    default: ;
                endcase
            end
        end
    end

    logic w_unused;
    assign w_unused = &{1'b0, avmm_slv_wrdata[31:16], w_lfsr[15:14]};

    assign avs_source_sof   = r_sof;
    assign avs_source_valid = r_valid;
    assign avs_source_data  = r_data;
    assign avs_source_eof   = r_eof;
    assign avmm_slv_rddata  = r_rddata;

endmodule

// File: tb/tb_avs_frame_source.sv
// Directed bench for avs_frame_source: register access, frame shape per pattern,
// shadowing of mid-frame writes and reset during a line.
module tb_avs_frame_source;

    localparam int W = 8;
    localparam int H = 4;

    logic        avs_clk = 1'b0;
    logic        avs_reset = 1'b1;
    logic        avs_source_sof, avs_source_valid, avs_source_eof;
    logic [15:0] avs_source_data;
    logic        avmm_slv_wr = 1'b0;
    logic        avmm_slv_rd = 1'b0;
    logic [3:0]  avmm_slv_address = '0;
    logic [31:0] avmm_slv_wrdata = '0;
    logic [31:0] avmm_slv_rddata;

    int n_checks = 0;
    int n_fail   = 0;

    logic [18:0] trace[$];
    logic        cap = 1'b0;

    always #5 avs_clk = ~avs_clk;

    avs_frame_source #(
        .video_width    (W),
        .video_height   (H),
        .hblank_default (16),
        .vblank_default (64),
        .lfsr_seed      (16'hACE1)
    ) dut (
        .avs_clk          (avs_clk),
        .avs_reset        (avs_reset),
        .avs_source_sof   (avs_source_sof),
        .avs_source_valid (avs_source_valid),
        .avs_source_data  (avs_source_data),
        .avs_source_eof   (avs_source_eof),
        .avmm_slv_wr      (avmm_slv_wr),
        .avmm_slv_rd      (avmm_slv_rd),
        .avmm_slv_address (avmm_slv_address),
        .avmm_slv_wrdata  (avmm_slv_wrdata),
        .avmm_slv_rddata  (avmm_slv_rddata)
    );

    always @(negedge avs_clk) begin
        if (cap) trace.push_back({avs_source_sof, avs_source_eof, avs_source_valid, avs_source_data});
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge avs_clk);
        #1;
    endtask

    task automatic bus_write(input logic [3:0] addr, input logic [31:0] data);
        avmm_slv_wr      = 1'b1;
        avmm_slv_address = addr;
        avmm_slv_wrdata  = data;
        tick();
        avmm_slv_wr = 1'b0;
        $display("WR  addr=%0d data=%h", addr, data);
    endtask

    task automatic rd_check(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        avmm_slv_rd      = 1'b1;
        avmm_slv_address = addr;
        tick();
        avmm_slv_rd = 1'b0;
        $display("RD  addr=%0d data=%h", addr, avmm_slv_rddata);
        check(tag, avmm_slv_rddata, exp);
    endtask

    // One frame: enable, optional mid-frame register traffic, then wait for EOF and VBLANK.
    task automatic do_frame(input logic [1:0] pat, input bit mid, input int vb);
        bit seen = 0;
        trace.delete();
        cap = 1'b1;
        bus_write(4'd0, {29'd0, pat, 1'b1});
        if (!mid) begin
            bus_write(4'd0, {29'd0, pat, 1'b0});
        end else begin
            repeat (8) tick();
            rd_check("busy_mid", 4'd6, 32'd1);
            bus_write(4'd2, 32'h5555);
            bus_write(4'd0, 32'h4);
        end
        for (int i = 0; i < 2000 && !seen; i++) begin
            if (avs_source_eof) seen = 1;
            else tick();
        end
        if (!seen) check("eof_timeout", 32'd0, 32'd1);
        repeat (vb + 3) tick();
        cap = 1'b0;
        rd_check("idle_after", 4'd6, 32'd0);
        $display("FRM pattern=%0d cycles=%0d", pat, trace.size());
    endtask

    task automatic exp_at(input int idx, input logic [18:0] e, input string tag);
        logic [18:0] g;
        g = (idx >= 0 && idx < trace.size()) ? trace[idx] : 19'h7FFFF;
        if (!g[16]) g[15:0] = 16'h0;
        check(tag, {13'd0, g}, {13'd0, e});
    endtask

    task automatic check_frame(input logic [1:0] pat, input logic [15:0] temp,
                               input logic [13:0] cst, input int hbe, output logic [15:0] first_pix);
        int si = -1, ei = -1, nsof = 0, neof = 0, p;
        logic [15:0] lf = 16'hACE1;
        logic [15:0] pix;
        foreach (trace[i]) begin
            if (trace[i][18]) begin nsof++; if (si < 0) si = i; end
            if (trace[i][17]) begin neof++; if (ei < 0) ei = i; end
        end
        check("sof_pos", si, 32'd2);
        check("eof_pos", ei - si + 1, 2 + H * (hbe + 1 + W));
        check("sof_count", nsof, 32'd1);
        check("eof_count", neof, 32'd1);
        first_pix = (si >= 0 && si + hbe + 2 < trace.size()) ? trace[si + hbe + 2][15:0] : 16'hFFFF;
        p = si;
        exp_at(p++, {3'b101, 16'h0}, "sof_word");
        for (int l = 0; l < H; l++) begin
            for (int h = 0; h < hbe; h++) exp_at(p++, 19'h0, $sformatf("hblank l%0d c%0d", l, h));
            exp_at(p++, {3'b001, temp}, $sformatf("temp l%0d", l));
            for (int x = 0; x < W; x++) begin
                case (pat)
                    2'd0:    pix = 16'(x);
                    2'd1:    pix = 16'(l);
                    2'd2:    pix = {2'b00, cst};
                    default: pix = {2'b00, lf[13:0]};
                endcase
                lf = {lf[14:0], lf[15] ^ lf[13] ^ lf[12] ^ lf[10]};
                exp_at(p++, {3'b001, pix}, $sformatf("pix p%0d l%0d x%0d", pat, l, x));
            end
        end
        exp_at(p, {3'b011, 16'h0}, "eof_word");
    endtask

    initial begin
        logic [15:0] fp0, fp1;
        repeat (3) tick();
        check("out_in_reset", {avs_source_sof, avs_source_eof, avs_source_valid, avs_source_data}, 32'd0);
        avs_reset = 1'b0;
        tick();
        check("reset_out", {avs_source_sof, avs_source_eof, avs_source_valid, avs_source_data}, 32'd0);
        check("reset_rddata", avmm_slv_rddata, 32'd0);
        rd_check("rst_ctrl", 4'd0, 32'd0);
        rd_check("rst_const", 4'd1, 32'd0);
        rd_check("rst_temp", 4'd2, 32'd0);
        rd_check("rst_hblank", 4'd3, 32'd16);
        rd_check("rst_vblank", 4'd4, 32'd64);
        rd_check("rst_fcnt", 4'd5, 32'd0);
        rd_check("rst_status", 4'd6, 32'd0);
        rd_check("unmapped", 4'd9, 32'd0);
        tick();
        check("rddata_idle", avmm_slv_rddata, 32'd0);
        bus_write(4'd5, 32'hDEAD);
        rd_check("fcnt_ro", 4'd5, 32'd0);

        // Write and read of the same address in one cycle returns the old value.
        avmm_slv_wr = 1'b1; avmm_slv_rd = 1'b1;
        avmm_slv_address = 4'd3; avmm_slv_wrdata = 32'd2;
        tick();
        avmm_slv_wr = 1'b0; avmm_slv_rd = 1'b0;
        check("wr_rd_old", avmm_slv_rddata, 32'd16);
        rd_check("hblank_new", 4'd3, 32'd2);
        bus_write(4'd4, 32'd3);

        do_frame(2'd0, 1'b0, 3);
        check_frame(2'd0, 16'h0, 14'h0, 2, fp0);
        rd_check("fcnt_1", 4'd5, 32'd1);

        bus_write(4'd3, 32'd0);
        bus_write(4'd2, 32'h1234);
        do_frame(2'd0, 1'b0, 3);
        check_frame(2'd0, 16'h1234, 14'h0, 1, fp0);

        bus_write(4'd1, 32'hFFFF);
        rd_check("const_mask", 4'd1, 32'h3FFF);
        do_frame(2'd2, 1'b0, 3);
        check_frame(2'd2, 16'h1234, 14'h3FFF, 1, fp0);
        do_frame(2'd1, 1'b0, 3);
        check_frame(2'd1, 16'h1234, 14'h3FFF, 1, fp0);

        do_frame(2'd3, 1'b0, 3);
        check_frame(2'd3, 16'h1234, 14'h3FFF, 1, fp0);
        do_frame(2'd3, 1'b0, 3);
        check_frame(2'd3, 16'h1234, 14'h3FFF, 1, fp1);
        check("lfsr_first0", fp0, 16'h2CE1);
        check("lfsr_first1", fp1, 16'h2CE1);

        do_frame(2'd0, 1'b1, 3);
        check_frame(2'd0, 16'h1234, 14'h3FFF, 1, fp0);
        rd_check("fcnt_7", 4'd5, 32'd7);
        rd_check("temp_new", 4'd2, 32'h5555);
        rd_check("ctrl_new", 4'd0, 32'h4);

        bus_write(4'd3, 32'd2);
        bus_write(4'd0, 32'd1);
        begin
            bit seen = 0;
            for (int i = 0; i < 200 && !seen; i++) begin
                if (avs_source_sof) seen = 1;
                else tick();
            end
            if (!seen) check("sof_timeout", 32'd0, 32'd1);
        end
        repeat (6) tick();
        check("pre_reset_valid", avs_source_valid, 32'd1);
        avs_reset = 1'b1;
        tick();
        check("mid_reset_out", {avs_source_sof, avs_source_eof, avs_source_valid, avs_source_data}, 32'd0);
        avs_reset = 1'b0;
        tick();
        check("post_reset_out", {avs_source_sof, avs_source_eof, avs_source_valid, avs_source_data}, 32'd0);
        rd_check("post_reset_status", 4'd6, 32'd0);
        rd_check("post_reset_fcnt", 4'd5, 32'd0);
        rd_check("post_reset_hblank", 4'd3, 32'd16);
        bus_write(4'd3, 32'd2);
        bus_write(4'd4, 32'd3);
        do_frame(2'd0, 1'b0, 3);
        check_frame(2'd0, 16'h0, 14'h0, 2, fp0);
        rd_check("restart_fcnt", 4'd5, 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
